// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: data_ok exactly LATENCY cycles after acceptance, one access in flight.
// addr_ok only in IDLE; DBUS_SRAM_MISALIGN_CHK_EN flags misaligned accesses and suppresses them.
package dbus_sram_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_responder
  import dbus_sram_pkg::*;
#(
  parameter int unsigned DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy,
  output logic       misalign
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  msize_t      size_q, size_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        data_ok_q, data_ok_d;
  logic [63:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;

  logic [63:0] mem_q [DEPTH];

  logic [63:0] off;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        misal;
  logic        accept;
  logic        mem_we;
  logic [63:0] wmerge;
  logic        unused_off;

  assign accept = (state_q == S_IDLE) && dreq.valid;

  // Outside an acceptance the _d copies equal the latched request, so one
  // decode serves both the RESP-entry read and the RESP-cycle write.
  always_comb begin
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    if (accept) begin
      addr_d   = dreq.addr;
      size_d   = dreq.size;
      strobe_d = dreq.strobe;
      wdata_d  = dreq.data;
      wr_d     = |dreq.strobe;
    end
  end

  assign off        = addr_d - BASE;
  assign idx        = off[AW+2:3];
  assign in_range   = (addr_d >= BASE) && (addr_d < LIMIT);
  assign unused_off = ^{off[63:AW+3], off[2:0]};

`ifdef DBUS_SRAM_MISALIGN_CHK_EN
  always_comb begin
    misal = 1'b0;
    case (size_d)
      MSIZE2:  misal = addr_d[0];
      MSIZE4:  misal = |addr_d[1:0];
      MSIZE8:  misal = |addr_d[2:0];
      default: misal = 1'b0;
    endcase
  end
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dreq.valid) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response fields are registered on entry to RESP, so nothing but
  // addr_ok depends combinationally on dreq.
  always_comb begin
    data_ok_d  = (state_d == S_RESP);
    misalign_d = (state_d == S_RESP) && misal;
    rdata_d    = '0;
    if ((state_d == S_RESP) && !wr_d && in_range && !misal) begin
      rdata_d = mem_q[idx];
    end
  end

  always_comb begin
    wmerge = mem_q[idx];
    for (int i = 0; i < 8; i++) begin
      if (strobe_q[i]) begin
        wmerge[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_we = (state_q == S_RESP) && wr_q && in_range && !misal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= MSIZE1;
      strobe_q   <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      data_ok_q  <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      strobe_q   <= strobe_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Array contents survive reset; a reset before RESP leaves mem_we low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wmerge;
    end
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = data_ok_q;
    dresp.data    = rdata_q;
  end

  assign busy     = (state_q != S_IDLE);
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder: LATENCY=2 and LATENCY=1 instances, DEPTH=16.
module tb_dbus_sram_responder;
  import dbus_sram_pkg::*;

  localparam logic [63:0] W10_INIT = 64'h1122_3344_BBBB_BBBB;
`ifdef DBUS_SRAM_MISALIGN_CHK_EN
  localparam logic [63:0] W10_MIS  = 64'h1122_3344_BBBB_BBBB;
  localparam logic        MIS_EXP  = 1'b1;
  localparam logic [63:0] MISRD    = 64'h0;
`else
  localparam logic [63:0] W10_MIS  = 64'h1122_CCCC_CCCC_BBBB;
  localparam logic        MIS_EXP  = 1'b0;
  localparam logic [63:0] MISRD    = 64'h1122_CCCC_CCCC_BBBB;
`endif

  logic       clk;
  logic       reset;
  dbus_req_t  req2, req1;
  dbus_resp_t resp2, resp1;
  logic       busy2, busy1, mis2, mis1;
  int         nvec = 0;
  int         nerr = 0;

  dbus_sram_responder #(.DEPTH(16), .LATENCY(2), .BASE(64'h8000_0000)) dut (
    .clk(clk), .reset(reset), .dreq(req2), .dresp(resp2), .busy(busy2), .misalign(mis2)
  );

  dbus_sram_responder #(.DEPTH(16), .LATENCY(1), .BASE(64'h8000_0000)) dut1 (
    .clk(clk), .reset(reset), .dreq(req1), .dresp(resp1), .busy(busy1), .misalign(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 of the acceptance cycle T; returns at posedge+1 of T+3 with valid low.
  task automatic acc2(input string tag, input logic [63:0] a, input msize_t sz,
                      input logic [7:0] st, input logic [63:0] d,
                      input logic [63:0] exp_data, input logic exp_mis);
    req2.valid  = 1'b1;
    req2.addr   = a;
    req2.size   = sz;
    req2.strobe = st;
    req2.data   = d;
    @(negedge clk);
    chk({tag, ".T.addr_ok"}, 64'(resp2.addr_ok), 64'd1);
    chk({tag, ".T.data_ok"}, 64'(resp2.data_ok), 64'd0);
    chk({tag, ".T.busy"}, 64'(busy2), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".T1.addr_ok"}, 64'(resp2.addr_ok), 64'd0);
    chk({tag, ".T1.data_ok"}, 64'(resp2.data_ok), 64'd0);
    chk({tag, ".T1.busy"}, 64'(busy2), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".T2.addr_ok"}, 64'(resp2.addr_ok), 64'd0);
    chk({tag, ".T2.data_ok"}, 64'(resp2.data_ok), 64'd1);
    chk({tag, ".T2.data"}, resp2.data, exp_data);
    chk({tag, ".T2.misalign"}, 64'(mis2), 64'(exp_mis));
    @(posedge clk); #1;
    req2.valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req2  = '0;
    req1  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.addr_ok", 64'(resp2.addr_ok), 64'd0);
    chk("rst.data_ok", 64'(resp2.data_ok), 64'd0);
    chk("rst.data", resp2.data, 64'd0);
    chk("rst.busy", 64'(busy2), 64'd0);
    chk("rst.misalign", 64'(mis2), 64'd0);
    chk("rst1.busy", 64'(busy1), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full write, read-back on the cycle after RESP, partial-strobe merge.
    acc2("wr_full", 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    acc2("rd_full", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    acc2("wr_part", 64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0, 1'b0);
    acc2("rd_part", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, W10_INIT, 1'b0);

    // Out-of-range: below BASE, and BASE+8*DEPTH which aliases word 0 by index.
    acc2("wr_w0", 64'h8000_0000, MSIZE8, 8'hFF, 64'h0102_0304_0506_0708, 64'h0, 1'b0);
    acc2("rd_low", 64'h0000_1000, MSIZE8, 8'h00, 64'h0, 64'h0, 1'b0);
    acc2("wr_high", 64'h8000_0080, MSIZE8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b0);
    acc2("rd_w0", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, 64'h0102_0304_0506_0708, 1'b0);

    // Reset during WAIT of a write.
    req2.valid  = 1'b1;
    req2.addr   = 64'h8000_0010;
    req2.size   = MSIZE8;
    req2.strobe = 8'hFF;
    req2.data   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("rstw.accept", 64'(resp2.addr_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.wait_busy", 64'(busy2), 64'd1);
    reset = 1'b1;
    req2.valid = 1'b0;
    #1;
    chk("rstw.busy", 64'(busy2), 64'd0);
    chk("rstw.data_ok", 64'(resp2.data_ok), 64'd0);
    chk("rstw.data", resp2.data, 64'd0);
    chk("rstw.misalign", 64'(mis2), 64'd0);
    chk("rstw.addr_ok", 64'(resp2.addr_ok), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.next_busy", 64'(busy2), 64'd0);
    chk("rstw.next_data_ok", 64'(resp2.data_ok), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    acc2("rd_after_rst", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, W10_INIT, 1'b0);

    // Misaligned 4-byte write at offset 2, then a misaligned 8-byte read.
    acc2("wr_mis", 64'h8000_0012, MSIZE4, 8'h3C, 64'h0000_CCCC_CCCC_0000, 64'h0, MIS_EXP);
    acc2("rd_mis_chk", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, W10_MIS, 1'b0);
    acc2("rd_mis", 64'h8000_0014, MSIZE8, 8'h00, 64'h0, MISRD, MIS_EXP);

    // LATENCY=1 instance: one write, then three back-to-back reads with valid held.
    req1.valid  = 1'b1;
    req1.addr   = 64'h8000_0008;
    req1.size   = MSIZE8;
    req1.strobe = 8'hFF;
    req1.data   = 64'h5555_6666_7777_8888;
    @(negedge clk);
    chk("l1.wr.addr_ok", 64'(resp1.addr_ok), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1.wr.data_ok", 64'(resp1.data_ok), 64'd1);
    chk("l1.wr.busy", 64'(busy1), 64'd1);
    @(posedge clk); #1;
    req1.strobe = 8'h00;
    req1.data   = 64'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("l1.rd%0d.acc.addr_ok", k), 64'(resp1.addr_ok), 64'd1);
      chk($sformatf("l1.rd%0d.acc.data_ok", k), 64'(resp1.data_ok), 64'd0);
      chk($sformatf("l1.rd%0d.acc.busy", k), 64'(busy1), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("l1.rd%0d.resp.addr_ok", k), 64'(resp1.addr_ok), 64'd0);
      chk($sformatf("l1.rd%0d.resp.data_ok", k), 64'(resp1.data_ok), 64'd1);
      chk($sformatf("l1.rd%0d.resp.busy", k), 64'(busy1), 64'd1);
      chk($sformatf("l1.rd%0d.resp.data", k), resp1.data, 64'h5555_6666_7777_8888);
      @(posedge clk); #1;
    end
    req1.valid = 1'b0;
    @(negedge clk);
    chk("l1.idle.data_ok", 64'(resp1.data_ok), 64'd0);
    chk("l1.idle.busy", 64'(busy1), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
